// File: rtl/note_score_tracker_if.sv
// Handshake bundle between the song sequencer and the note score tracker.
// The sequencer drives the key vectors and song pulses; the tracker returns the grade and counters.
interface note_score_tracker_if #(
  parameter int KEYS = 10
);
  logic [KEYS-1:0] store;
  logic [KEYS-1:0] NOTE;
  logic            song_start;
  logic            note_tick;
  logic            song_end;
  logic [2:0]      level;
  logic            level_valid;
  logic            busy;
  logic [7:0]      perfect_cnt;
  logic [7:0]      miss_cnt;

  modport master (
    output store, NOTE, song_start, note_tick, song_end,
    input  level, level_valid, busy, perfect_cnt, miss_cnt
  );

  modport slave (
    input  store, NOTE, song_start, note_tick, song_end,
    output level, level_valid, busy, perfect_cnt, miss_cnt
  );
endinterface

// File: rtl/note_score_tracker.sv
// Learning-mode scorer: rates each played note perfect/good/miss by its mismatch time,
// accumulates points over a song and emits a grade level 0 (S) .. 4 (D) at song end.
module note_score_tracker #(
  parameter int CNT_W       = 27,
  parameter int TOL_CYCLES  = 100000,
  parameter int GOOD_CYCLES = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  note_score_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] GOOD_C  = CNT_W'(GOOD_CYCLES);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] err_now_s;
  logic             note_seen_r;
  logic             seen_now_s;
  logic             note_on_s;
  logic             miss_cyc_s;
  logic             close_s;
  logic [8:0]       points_r;
  logic [7:0]       total_r;
  logic [7:0]       perfect_cnt_r;
  logic [7:0]       good_cnt_r;
  logic [7:0]       miss_cnt_r;
  logic [2:0]       level_r;
  logic             level_valid_r;
  logic             busy_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  function automatic logic [8:0] sat_add_pts(input logic [8:0] p, input logic [1:0] a);
    logic [9:0] s;
    s = {1'b0, p} + {8'd0, a};
    return (s > 10'd510) ? 9'd510 : s[8:0];
  endfunction

  // Grade thresholds as ratios of points to the maximum 2*total, cross-multiplied to stay integer
  function automatic logic [2:0] grade(input logic [8:0] pts, input logic [7:0] tot);
    logic [13:0] mx;
    logic [13:0] p20;
    logic [13:0] p10;
    mx  = 14'({tot, 1'b0});
    p20 = 14'(pts) * 14'd20;
    p10 = 14'(pts) * 14'd10;
    if (tot == 8'd0)               return 3'd4;
    else if (p20 >= mx * 14'd19)   return 3'd0;
    else if (p10 >= mx * 14'd8)    return 3'd1;
    else if (p10 >= mx * 14'd6)    return 3'd2;
    else if (p10 >= mx * 14'd4)    return 3'd3;
    else                           return 3'd4;
  endfunction

  assign note_on_s  = (bus.NOTE != '0);
  assign miss_cyc_s = note_on_s && (bus.store != bus.NOTE);
  assign seen_now_s = note_seen_r | note_on_s;
  assign close_s    = bus.note_tick | bus.song_end;

  // Mismatch count including the current cycle's compare, saturating
  always_comb begin
    err_now_s = err_cnt_r;
    if (miss_cyc_s && (err_cnt_r != ERR_MAX)) begin
      err_now_s = err_cnt_r + CNT_W'(1);
    end else begin
      err_now_s = err_cnt_r;
    end
  end

  // Next-state logic; song_start wins from any state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.song_start ? PLAY : IDLE;
      PLAY: begin
        if (bus.song_start)     state_s = PLAY;
        else if (bus.song_end)  state_s = FINAL;
        else                    state_s = PLAY;
      end
      FINAL:   state_s = bus.song_start ? PLAY : DONE;
      DONE:    state_s = bus.song_start ? PLAY : DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Registered busy flag follows the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_r <= 1'b0;
    else      busy_r <= (state_s == PLAY) || (state_s == FINAL);
  end

  // Per-note mismatch tracking, note classification and grade computation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_r     <= '0;
      note_seen_r   <= 1'b0;
      points_r      <= 9'd0;
      total_r       <= 8'd0;
      perfect_cnt_r <= 8'd0;
      good_cnt_r    <= 8'd0;
      miss_cnt_r    <= 8'd0;
      level_r       <= 3'd0;
      level_valid_r <= 1'b0;
    end else if (bus.song_start) begin
      err_cnt_r     <= '0;
      note_seen_r   <= 1'b0;
      points_r      <= 9'd0;
      total_r       <= 8'd0;
      perfect_cnt_r <= 8'd0;
      good_cnt_r    <= 8'd0;
      miss_cnt_r    <= 8'd0;
      level_valid_r <= 1'b0;
    end else begin
      case (state_r)
        PLAY: begin
          if (close_s) begin
            err_cnt_r   <= '0;
            note_seen_r <= 1'b0;
            // A pure rest (no non-zero NOTE seen) is not a scored note
            if (seen_now_s) begin
              total_r <= sat_inc8(total_r);
              if (err_now_s < TOL_C) begin
                perfect_cnt_r <= sat_inc8(perfect_cnt_r);
                points_r      <= sat_add_pts(points_r, 2'd2);
              end else if (err_now_s < GOOD_C) begin
                good_cnt_r <= sat_inc8(good_cnt_r);
                points_r   <= sat_add_pts(points_r, 2'd1);
              end else begin
                miss_cnt_r <= sat_inc8(miss_cnt_r);
              end
            end
          end else begin
            err_cnt_r   <= err_now_s;
            note_seen_r <= seen_now_s;
          end
        end
        FINAL: begin
          level_r       <= grade(points_r, total_r);
          level_valid_r <= 1'b1;
        end
        default: begin
          level_valid_r <= level_valid_r;
        end
      endcase
    end
  end

  assign bus.level       = level_r;
  assign bus.level_valid = level_valid_r;
  assign bus.busy        = busy_r;
  assign bus.perfect_cnt = perfect_cnt_r;
  assign bus.miss_cnt    = miss_cnt_r;

endmodule
